// File: rtl/jtdd_snd_cmd_pkg.sv
// Shared definitions for the main-CPU to sound-CPU command path:
// sequencer state encoding and default sizing parameters.
package jtdd_snd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_IRQ,
        ST_WAIT,
        ST_RESET
    } snd_state_t;

    localparam int DEF_AW   = 2;
    localparam int DEF_IRQW = 4;
    localparam int DEF_RSTW = 16;

endpackage

// File: rtl/jtdd_snd_fifo.sv
// Command FIFO: 2^AW byte entries, wrapping pointers and an AW+1 bit fill level.
// All updates are qualified by cen; flush empties the queue and wins over push/pop.
module jtdd_snd_fifo #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = level == (AW+1)'(2**AW);
    assign empty   = level == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (cen) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cen && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jtdd_snd_cmd.sv
// Sound command port: queues main-CPU command bytes, presents them one at a time
// to the sound CPU with a timed interrupt, and controls the sound-CPU reset line.
module jtdd_snd_cmd
    import jtdd_snd_cmd_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int IRQW = DEF_IRQW,
    parameter int RSTW = DEF_RSTW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_cen,
    input  logic [7:0] cpu_dout,
    input  logic       cmd_we,
    input  logic       rst_we,
    input  logic       latch_rd,
    output logic [7:0] snd_latch,
    output logic       snd_irq,
    output logic       snd_rstb,
    output logic [7:0] status
);

    localparam int IRQ_CW = $clog2(IRQW + 1);
    localparam int RST_CW = $clog2(RSTW + 1);

    snd_state_t        state, state_nxt;
    logic [IRQ_CW-1:0] irq_cnt;
    logic [RST_CW-1:0] rst_cnt;
    logic              rst_req, ovf, rd_l, ack_pend;
    logic              rd_edge, rst_on, rst_off;
    logic              push, pop, flush, full, empty;
    logic [7:0]        fifo_dout;
    logic [AW:0]       level;
    logic [2:0]        lvl3;

    assign rd_edge = latch_rd & ~rd_l;
    assign rst_on  = rst_we & cpu_dout[0];
    assign rst_off = rst_we & ~cpu_dout[0];
    assign lvl3    = 3'(level);
    assign status  = {full, empty, state != ST_IDLE, 2'b00, lvl3};

    jtdd_snd_fifo #(.AW(AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cpu_cen),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (cpu_dout),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        if (cpu_cen) begin
            if (rst_on) begin
                state_nxt = ST_RESET;
                flush     = 1'b1;
            end else begin
                push = cmd_we && (state != ST_RESET);
                case (state)
                    ST_IDLE:  if (!empty && snd_rstb) state_nxt = ST_LOAD;
                    ST_LOAD: begin
                        pop       = 1'b1;
                        state_nxt = ST_IRQ;
                    end
                    ST_IRQ:   if (irq_cnt == IRQ_CW'(IRQW - 1)) state_nxt = ST_WAIT;
                    ST_WAIT:  if (rd_edge || ack_pend) state_nxt = ST_IDLE;
                    // Release needs both the 0 write and the minimum low time.
                    ST_RESET: if (rst_cnt >= RST_CW'(RSTW - 1) && (!rst_req || rst_off))
                                  state_nxt = ST_IDLE;
                    default:  state_nxt = ST_RESET;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            irq_cnt   <= '0;
            rst_cnt   <= '0;
            rst_req   <= 1'b0;
            ovf       <= 1'b0;
            rd_l      <= 1'b0;
            ack_pend  <= 1'b0;
            snd_latch <= 8'h00;
            snd_irq   <= 1'b0;
            snd_rstb  <= 1'b0;
        end else if (cpu_cen) begin
            state    <= state_nxt;
            rd_l     <= latch_rd;
            snd_irq  <= state_nxt == ST_IRQ;
            snd_rstb <= state_nxt != ST_RESET;
            irq_cnt  <= (state == ST_IRQ) ? irq_cnt + IRQ_CW'(1) : '0;
            ack_pend <= (state == ST_IRQ) && (ack_pend || rd_edge);
            if (pop) snd_latch <= fifo_dout;
            if (rst_on) begin
                rst_cnt <= '0;
                rst_req <= 1'b1;
            end else begin
                if (state == ST_RESET && rst_cnt != RST_CW'(RSTW - 1))
                    rst_cnt <= rst_cnt + RST_CW'(1);
                if (rst_off) rst_req <= 1'b0;
            end
            if (rst_we)
                ovf <= 1'b0;
            else if (cmd_we && state != ST_RESET && full)
                ovf <= 1'b1;
        end
    end

endmodule
